// File: rtl/cond_fork5_issue_ctrl_if.sv
// Handshake and branch bundle between the issue controller
// and its upstream source / downstream 5-way fork.
interface cond_fork5_issue_ctrl_if;
   logic       i_req;
   logic [4:0] i_mask;
   logic       o_ack;
   logic       o_drive;
   logic [4:0] o_valid;
   logic [4:0] i_free;
   logic [4:0] o_pending;
   logic       o_busy;
   logic       o_timeout;
   logic       i_clr;

   modport master (
      output i_req, i_mask, i_free, i_clr,
      input  o_ack, o_drive, o_valid, o_pending, o_busy, o_timeout
   );

   modport slave (
      input  i_req, i_mask, i_free, i_clr,
      output o_ack, o_drive, o_valid, o_pending, o_busy, o_timeout
   );
endinterface

// File: rtl/cond_fork5_issue_ctrl.sv
// Issue controller ahead of the 5-way conditional fork:
// drives the fork, then joins on a free edge from every selected branch.
module cond_fork5_issue_ctrl #(
   parameter int DRIVE_LEN = 1,
   parameter int TO_W      = 8,
   parameter int TO_MAX    = 200
) (
   input logic                   clk,
   input logic                   rst,
   cond_fork5_issue_ctrl_if.slave bus
);

   typedef enum logic [1:0] {IDLE, DRIVE, WAIT, ERR} state_t;

   localparam logic [3:0]      DLAST = 4'(DRIVE_LEN - 1);
   localparam logic [TO_W-1:0] TLAST = TO_W'(TO_MAX - 1);

   state_t          state, state_nxt;
   logic [4:0]      mask_r, mask_nxt;
   logic [4:0]      pend, pend_nxt;
   logic [4:0]      free_q;
   logic [4:0]      fedge;
   logic [4:0]      left;
   logic [3:0]      dcnt, dcnt_nxt;
   logic [TO_W-1:0] tcnt, tcnt_nxt;
   logic            xfer;

   assign fedge = bus.i_free & ~free_q;
   assign left  = pend & ~fedge;
   assign xfer  = bus.i_req & (state == IDLE);

   // State and datapath registers; free_q preset high so held frees are not edges.
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         mask_r <= '0;
         pend   <= '0;
         dcnt   <= '0;
         tcnt   <= '0;
         free_q <= 5'b11111;
      end else begin
         state  <= state_nxt;
         mask_r <= mask_nxt;
         pend   <= pend_nxt;
         dcnt   <= dcnt_nxt;
         tcnt   <= tcnt_nxt;
         free_q <= bus.i_free;
      end
   end

   // Next-state: drive for DRIVE_LEN cycles, then wait for the strict join.
   always_comb begin
      state_nxt = state;
      mask_nxt  = mask_r;
      pend_nxt  = pend;
      dcnt_nxt  = dcnt;
      tcnt_nxt  = tcnt;
      unique case (state)
         IDLE: begin
            if (xfer && (bus.i_mask != 5'b0)) begin
               mask_nxt  = bus.i_mask;
               pend_nxt  = bus.i_mask;
               dcnt_nxt  = '0;
               state_nxt = DRIVE;
            end
         end
         DRIVE: begin
            pend_nxt = left;
            if (dcnt == DLAST) begin
               tcnt_nxt  = '0;
               state_nxt = WAIT;
            end else begin
               dcnt_nxt = dcnt + 4'd1;
            end
         end
         WAIT: begin
            pend_nxt = left;
            if (left == 5'b0) begin
               state_nxt = IDLE;
            end else if (tcnt == TLAST) begin
               state_nxt = ERR;
            end else begin
               tcnt_nxt = tcnt + 1'b1;
            end
         end
         ERR: begin
            if (bus.i_clr) begin
               pend_nxt  = '0;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign bus.o_ack     = (state == IDLE);
   assign bus.o_drive   = (state == DRIVE);
   assign bus.o_busy    = (state == DRIVE) || (state == WAIT);
   assign bus.o_valid   = bus.o_busy ? mask_r : 5'b0;
   assign bus.o_pending = pend;
   assign bus.o_timeout = (state == ERR);

endmodule
